// File: rtl/pixel_pkg.sv
// ============================================================================
// Module   : pixel_pkg
// Purpose  : Shared constants, types and the RGB565-to-luma helper used by
//            the pixel grayscale path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_pkg;

    // Button stable time at 25 MHz: 10 ms.
    localparam int c_debounce_cycles_default = 250000;

    // RGB565 field layout.
    localparam int c_r_w   = 5;
    localparam int c_g_w   = 6;
    localparam int c_b_w   = 5;
    localparam int c_r_lsb = 11;
    localparam int c_g_lsb = 5;
    localparam int c_b_lsb = 0;

    // BT.601 luma weights scaled by 256 (sum = 256).
    localparam logic [15:0] c_coef_r = 16'd77;
    localparam logic [15:0] c_coef_g = 16'd150;
    localparam logic [15:0] c_coef_b = 16'd29;

    typedef logic [15:0] rgb565_t;

    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_GRAY   = 1'b1
    } conv_mode_t;

    // Expand each channel to 8 bits by bit replication, form the weighted
    // sum (max 256*255 = 65280, fits 16 bits) and repack Y as RGB565.
    function automatic rgb565_t rgb565_to_gray(input rgb565_t px);
        logic [c_r_w-1:0] r;
        logic [c_g_w-1:0] g;
        logic [c_b_w-1:0] b;
        logic [7:0]       r8;
        logic [7:0]       g8;
        logic [7:0]       b8;
        logic [15:0]      sum;
        logic [7:0]       y;
        r   = px[c_r_lsb +: c_r_w];
        g   = px[c_g_lsb +: c_g_w];
        b   = px[c_b_lsb +: c_b_w];
        r8  = {r, r[4:2]};
        g8  = {g, g[5:4]};
        b8  = {b, b[4:2]};
        sum = c_coef_r * {8'd0, r8} + c_coef_g * {8'd0, g8} + c_coef_b * {8'd0, b8};
        y   = sum[15:8];
        return {y[7:3], y[7:2], y[7:3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module   : button_debounce
// Purpose  : Two-flop synchroniser plus stable-time debouncer for an
//            active-low push button. Emits a one-cycle pulse on each
//            debounced press (high-to-low transition).
// Ports    : clk     - clock
//            rst     - synchronous active-high reset
//            btn_n   - raw asynchronous button, active-low
//            pressed - one-cycle pulse per debounced press
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
    import pixel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pressed;

    // Synchroniser and debounced level reset to "released" so a button held
    // across reset is not mistaken for a fresh press edge at reset time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_stable  <= 1'b1;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
        end else begin
            r_sync1   <= btn_n;
            r_sync2   <= r_sync1;
            r_pressed <= 1'b0;
            // Count consecutive cycles where the synchronised level differs
            // from the accepted one; any agreement restarts the count.
            if (r_sync2 != r_stable) begin
                if (r_cnt == c_cnt_last) begin
                    r_stable  <= r_sync2;
                    r_cnt     <= '0;
                    r_pressed <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pressed = r_pressed;

endmodule

`default_nettype wire

// File: rtl/pixel_gray_convert.sv
// ============================================================================
// Module   : pixel_gray_convert
// Purpose  : Two-stage valid/ready RGB565 pipeline that either passes pixels
//            through or converts them to grayscale. A debounced push button
//            toggles the requested mode, which is applied at frame starts.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            gray_btn_n          - raw mode button, active-low
//            in_valid/in_ready   - upstream handshake
//            in_data/in_sof      - RGB565 pixel, start-of-frame marker
//            out_valid/out_ready - downstream handshake
//            out_data/out_sof    - RGB565 pixel, start-of-frame marker
//            gray_active         - mode applied to the current frame
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_gray_convert
    import pixel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gray_btn_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_sof,
    input  logic        out_ready,
    output logic        gray_active
);

    logic       w_pressed;
    logic       w_advance;
    logic       w_in_accept;
    logic       w_sof_accept;
    conv_mode_t w_px_mode;
    rgb565_t    w_s2_data;

    logic       r_gray_req;
    logic       r_gray_active;
    logic       r_s1_valid;
    rgb565_t    r_s1_data;
    logic       r_s1_sof;
    conv_mode_t r_s1_mode;
    logic       r_out_valid;
    rgb565_t    r_out_data;
    logic       r_out_sof;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (gray_btn_n),
        .pressed(w_pressed)
    );

    // The whole pipeline moves as one: it advances whenever the output
    // register is empty or being drained.
    assign w_advance    = !r_out_valid || out_ready;
    assign w_in_accept  = in_valid && w_advance;
    assign w_sof_accept = w_in_accept && in_sof;

    // The sof pixel uses the mode being loaded on this same edge.
    assign w_px_mode = w_sof_accept ? conv_mode_t'(r_gray_req)
                                    : conv_mode_t'(r_gray_active);

    assign w_s2_data = (r_s1_mode == MODE_GRAY) ? rgb565_to_gray(r_s1_data) : r_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gray_req    <= 1'b0;
            r_gray_active <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_sof      <= 1'b0;
            r_s1_mode     <= MODE_BYPASS;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_sof     <= 1'b0;
        end else begin
            if (w_pressed) begin
                r_gray_req <= ~r_gray_req;
            end
            if (w_sof_accept) begin
                r_gray_active <= r_gray_req;
            end
            if (w_advance) begin
                r_s1_valid  <= in_valid;
                if (in_valid) begin
                    r_s1_data <= in_data;
                    r_s1_sof  <= in_sof;
                    r_s1_mode <= w_px_mode;
                end
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_s2_data;
                    r_out_sof  <= r_s1_sof;
                end
            end
        end
    end

    assign in_ready    = w_advance;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_sof     = r_out_sof;
    assign gray_active = r_gray_active;

endmodule

`default_nettype wire

// File: tb/tb_pixel_gray_convert.sv
// ============================================================================
// Module   : tb_pixel_gray_convert
// Purpose  : Scoreboard bench for pixel_gray_convert with directed pixels
//            and hand-computed expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_gray_convert;

    localparam int c_db = 8;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        lat_chk;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        gray_btn_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_sof;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sof;
    logic        out_ready;
    logic        gray_active;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cyc   = 0;

    pixel_gray_convert #(
        .DEBOUNCE_CYCLES(c_db)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gray_btn_n (gray_btn_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_ready  (out_ready),
        .gray_active(gray_active)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %04h expected no pixel", out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", {16'd0, out_data}, {16'd0, e.data});
                check("out_sof", {31'd0, out_sof}, {31'd0, e.sof});
                if (e.lat_chk) check("latency", cyc - e.cyc, 32'd2);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic s, input logic [15:0] e, input logic lat);
        exp_t x;
        int   n;
        logic ok;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        n  = 0;
        ok = 1'b0;
        while (!ok && n <= 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else begin
            x.data    = e;
            x.sof     = s;
            x.lat_chk = lat;
            x.cyc     = cyc;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        gray_btn_n = 1'b1;
        in_valid   = 1'b0;
        in_data    = 16'h0000;
        in_sof     = 1'b0;
        out_ready  = 1'b1;

        // Reset state.
        idle(3);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_sof", {31'd0, out_sof}, 32'd0);
        check("rst_gray_active", {31'd0, gray_active}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        idle(1);

        // Bypass frame, 2-cycle latency.
        send(16'h1234, 1'b1, 16'h1234, 1'b1);
        send(16'hABCD, 1'b0, 16'hABCD, 1'b1);
        drain();

        // Press held mid-frame: takes effect only at next sof.
        gray_btn_n = 1'b0;
        idle(20);
        gray_btn_n = 1'b1;
        idle(20);
        check("mode_mid_frame", {31'd0, gray_active}, 32'd0);
        send(16'h5555, 1'b0, 16'h5555, 1'b1);
        send(16'hF800, 1'b1, 16'h4A69, 1'b1);
        check("mode_after_sof", {31'd0, gray_active}, 32'd1);
        send(16'h07E0, 1'b0, 16'h94B2, 1'b1);
        send(16'h0000, 1'b0, 16'h0000, 1'b1);
        send(16'hFFFF, 1'b0, 16'hFFFF, 1'b1);
        drain();

        // Short glitch: no toggle.
        gray_btn_n = 1'b0;
        idle(3);
        gray_btn_n = 1'b1;
        idle(20);
        send(16'h001F, 1'b1, 16'h18E3, 1'b1);
        check("mode_after_glitch", {31'd0, gray_active}, 32'd1);
        drain();

        // Stall with pipeline full.
        out_ready = 1'b0;
        send(16'hF800, 1'b0, 16'h4A69, 1'b0);
        send(16'h07E0, 1'b0, 16'h94B2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_data", {16'd0, out_data}, 32'h4A69);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset mid-frame with two pixels in flight.
        out_ready = 1'b0;
        send(16'h1111, 1'b1, 16'h0000, 1'b0);
        send(16'h2222, 1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_gray_active", {31'd0, gray_active}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
        idle(10);
        send(16'h1234, 1'b1, 16'h1234, 1'b1);
        send(16'hF800, 1'b0, 16'hF800, 1'b1);
        drain();
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
